inst_ram_loader: RTL and testbench

INST_RAM_LOADER -- requirements
Module: inst_ram_loader

---
 rtl/inst_ram_loader.sv | 133 +++++++++++++
 tb/tb_inst_ram_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_loader.sv
// Instruction RAM loader: streams 32-bit words from a host into a 256-byte store, big-endian, one byte per cycle.
// Optional LOADER_CHECKSUM_EN adds a running 32-bit sum of accepted words on the checksum port.
module inst_ram_loader (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic [6:0]  word_cnt,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_WORD = 3'd1;
    localparam logic [2:0] WRITE_B0  = 3'd2;
    localparam logic [2:0] WRITE_B1  = 3'd3;
    localparam logic [2:0] WRITE_B2  = 3'd4;
    localparam logic [2:0] WRITE_B3  = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]  state;
    logic [7:0]  ptr;
    logic [6:0]  remaining;
    logic [31:0] word_q;
    logic [7:0]  mem [256];
    logic        mem_we;
    logic [7:0]  wr_byte;

    assign wr_ready = (state == WAIT_WORD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= IDLE;
            ptr       <= 8'd0;
            remaining <= 7'd0;
            word_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= word_cnt;
                        state     <= (word_cnt == 7'd0) ? DONE : WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (wr_valid) begin
                        word_q <= wr_data;
                        state  <= WRITE_B0;
                    end
                end
                WRITE_B0: begin
                    ptr   <= ptr + 8'd1;
                    state <= WRITE_B1;
                end
                WRITE_B1: begin
                    ptr   <= ptr + 8'd1;
                    state <= WRITE_B2;
                end
                WRITE_B2: begin
                    ptr   <= ptr + 8'd1;
                    state <= WRITE_B3;
                end
                WRITE_B3: begin
                    ptr       <= ptr + 8'd1;
                    remaining <= remaining - 7'd1;
                    state     <= (remaining == 7'd1) ? DONE : WAIT_WORD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mem_we  = 1'b0;
        wr_byte = 8'h00;
        case (state)
            WRITE_B0: begin mem_we = 1'b1; wr_byte = word_q[31:24]; end
            WRITE_B1: begin mem_we = 1'b1; wr_byte = word_q[23:16]; end
            WRITE_B2: begin mem_we = 1'b1; wr_byte = word_q[15:8];  end
            WRITE_B3: begin mem_we = 1'b1; wr_byte = word_q[7:0];   end
            default: ;
        endcase
    end

    // NOTE: the byte store has no reset; CLR aborts a session but keeps bytes already written.
    always_ff @(posedge CLK) begin
        if (mem_we && !CLR)
            mem[ptr] <= wr_byte;
    end

    logic [7:0] ra0, ra1, ra2, ra3;
    logic       unused_rd_hi;

    assign ra0          = rd_addr[7:0];
    assign ra1          = ra0 + 8'd1;
    assign ra2          = ra0 + 8'd2;
    assign ra3          = ra0 + 8'd3;
    assign unused_rd_hi = ^rd_addr[31:8];

    always_comb begin
        if (ra0[1:0] == 2'b00)
            rd_data = {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};
        else
            rd_data = {24'h000000, mem[ra0]};
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (CLR)
            checksum <= 32'd0;
        else if (state == IDLE && start)
            checksum <= 32'd0;
        else if (state == WAIT_WORD && wr_valid)
            checksum <= checksum + wr_data;
    end
`endif

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader; checksum checks are compiled in with LOADER_CHECKSUM_EN.
module tb_inst_ram_loader;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [6:0]  word_cnt = 7'd0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic [31:0] rd_addr = 32'h0;
    logic [31:0] rd_data;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int failures = 0;

    inst_ram_loader dut (
        .CLK(CLK),
        .CLR(CLR),
        .start(start),
        .base_addr(base_addr),
        .word_cnt(word_cnt),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .busy(busy),
        .done(done),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic read_at(input logic [31:0] a, output logic [31:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    // Single-word session used to seed known memory contents.
    task automatic load_word(input logic [7:0] base, input logic [31:0] w);
        start = 1'b1; base_addr = base; word_cnt = 7'd1;
        step;
        start = 1'b0; wr_valid = 1'b1; wr_data = w;
        step;
        wr_valid = 1'b0;
        repeat (6) step;
    endtask

    task automatic test_reset;
        CLR = 1'b1;
        step; step;
        CLR = 1'b0;
        checks++;
        if ({wr_ready, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: got ready/busy/done=%b expected 000", {wr_ready, busy, done});
        end
        step;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b expected 0", busy);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            failures++;
            $display("FAIL reset_checksum: got %h expected 00000000", checksum);
        end
`endif
    endtask

    task automatic test_single_word;
        logic [31:0] d;
        int done_at, dones, ready_in_write;
        start = 1'b1; base_addr = 8'h00; word_cnt = 7'd1;
        step;
        start = 1'b0;
        checks++;
        if ({busy, wr_ready, done} !== 3'b110) begin
            failures++;
            $display("FAIL single_wait: got busy/ready/done=%b expected 110", {busy, wr_ready, done});
        end
        wr_valid = 1'b1; wr_data = 32'hE0825005;
        step;
        wr_valid = 1'b0;
        // Counting the accept cycle as cycle 1, done must be high in cycle 6 only.
        done_at = 0; dones = 0; ready_in_write = 0;
        for (int i = 1; i <= 10; i++) begin
            if (done) begin
                dones++;
                if (done_at == 0) done_at = i + 1;
            end
            if (i <= 4 && wr_ready) ready_in_write++;
            step;
        end
        checks++;
        if (done_at != 6 || dones != 1) begin
            failures++;
            $display("FAIL single_done: got cycle=%0d pulses=%0d expected cycle=6 pulses=1", done_at, dones);
        end
        checks++;
        if (ready_in_write != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_busy: got ready_in_write=%0d busy=%b expected 0 0", ready_in_write, busy);
        end
        read_at(32'h0, d);
        checks++;
        if (d !== 32'hE0825005) begin
            failures++;
            $display("FAIL single_read0: got %h expected e0825005", d);
        end
        read_at(32'h3, d);
        checks++;
        if (d !== 32'h00000005) begin
            failures++;
            $display("FAIL single_read3: got %h expected 00000005", d);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        load_word(8'hFE, 32'h11223344);
        read_at(32'hABCD_0001, d);
        checks++;
        if (d !== 32'h00000044) begin
            failures++;
            $display("FAIL wrap_read1: got %h expected 00000044", d);
        end
        read_at(32'h0000_00FF, d);
        checks++;
        if (d !== 32'h00000022) begin
            failures++;
            $display("FAIL wrap_readff: got %h expected 00000022", d);
        end
        read_at(32'h0000_00FE, d);
        checks++;
        if (d !== 32'h00000011) begin
            failures++;
            $display("FAIL wrap_readfe: got %h expected 00000011", d);
        end
        read_at(32'h0000_0000, d);
        checks++;
        if (d !== 32'h33445005) begin
            failures++;
            $display("FAIL wrap_read0: got %h expected 33445005", d);
        end
    endtask

    task automatic test_zero_count;
        start = 1'b1; base_addr = 8'h40; word_cnt = 7'd0;
        step;
        start = 1'b0;
        checks++;
        if ({busy, done, wr_ready} !== 3'b110) begin
            failures++;
            $display("FAIL zero_first: got busy/done/ready=%b expected 110", {busy, done, wr_ready});
        end
        step;
        checks++;
        if ({busy, done, wr_ready} !== 3'b000) begin
            failures++;
            $display("FAIL zero_second: got busy/done/ready=%b expected 000", {busy, done, wr_ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [3];
        logic [31:0] d;
        int acc [3];
        int idx, dones;
        logic accepting, saw_done;
        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'hDEADBEEF;
        start = 1'b1; base_addr = 8'h80; word_cnt = 7'd3;
        step;
        wr_valid = 1'b1; wr_data = words[0];
        idx = 0; dones = 0; saw_done = 1'b0;
        for (int c = 0; c < 40 && !saw_done; c++) begin
            // Stray starts mid-session, once in a write state and once while waiting.
            if (c == 7 || c == 10) begin
                start = 1'b1; base_addr = 8'h00; word_cnt = 7'd0;
            end else begin
                start = 1'b0;
            end
            accepting = wr_ready && (idx < 3);
            if (accepting) acc[idx] = c;
            step;
            if (accepting) begin
                idx++;
                if (idx < 3) wr_data = words[idx];
            end
            if (done) begin
                dones++;
                saw_done = 1'b1;
            end
        end
        start = 1'b0; wr_valid = 1'b0;
        checks++;
        if (idx != 3 || !saw_done) begin
            failures++;
            $display("FAIL b2b_complete: got words=%0d done=%b expected 3 1", idx, saw_done);
        end
        checks++;
        if (idx == 3 && (acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5)) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d,%0d expected 5,5", acc[1] - acc[0], acc[2] - acc[1]);
        end else if (idx != 3) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d accepts expected 3", idx);
        end
        step;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_after: got busy/done=%b expected 00", {busy, done});
        end
        for (int k = 0; k < 3; k++) begin
            read_at(32'h80 + 32'(4 * k), d);
            checks++;
            if (d !== words[k]) begin
                failures++;
                $display("FAIL b2b_word%0d: got %h expected %h", k, d, words[k]);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h697CD245) begin
            failures++;
            $display("FAIL b2b_checksum: got %h expected 697cd245", checksum);
        end
`endif
    endtask

    task automatic test_abort;
        logic [31:0] d;
        int dones;
        load_word(8'h10, 32'h01020304);
        start = 1'b1; base_addr = 8'h10; word_cnt = 7'd1;
        step;
        start = 1'b0; wr_valid = 1'b1; wr_data = 32'hAABBCCDD;
        step;
        wr_valid = 1'b0;
        step; step;
        // Now in WRITE_B2; CLR must win over a simultaneous start.
        CLR = 1'b1; start = 1'b1; word_cnt = 7'd1;
        step;
        CLR = 1'b0; start = 1'b0;
        checks++;
        if ({busy, done, wr_ready} !== 3'b000) begin
            failures++;
            $display("FAIL abort_state: got busy/done/ready=%b expected 000", {busy, done, wr_ready});
        end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d busy/done cycles expected 0", dones);
        end
        read_at(32'h10, d);
        checks++;
        if (d !== 32'hAABB0304) begin
            failures++;
            $display("FAIL abort_mem: got %h expected aabb0304", d);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            failures++;
            $display("FAIL abort_checksum: got %h expected 00000000", checksum);
        end
`endif
    endtask

    task automatic test_wr_valid_ignored;
        logic [31:0] d;
        int ready_seen;
        wr_valid = 1'b1; wr_data = 32'hFFFFFFFF;
        repeat (3) step;
        wr_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_idle_busy: got %b expected 0", busy);
        end
        read_at(32'h10, d);
        checks++;
        if (d !== 32'hAABB0304) begin
            failures++;
            $display("FAIL ignore_idle_mem10: got %h expected aabb0304", d);
        end
        read_at(32'h0, d);
        checks++;
        if (d !== 32'h33445005) begin
            failures++;
            $display("FAIL ignore_idle_mem0: got %h expected 33445005", d);
        end
        start = 1'b1; base_addr = 8'h20; word_cnt = 7'd1;
        step;
        start = 1'b0; wr_valid = 1'b1; wr_data = 32'hCAFEF00D;
        step;
        wr_data = 32'h55555555;
        ready_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (wr_ready) ready_seen++;
            step;
        end
        wr_valid = 1'b0;
        checks++;
        if (ready_seen != 0) begin
            failures++;
            $display("FAIL ignore_write_ready: got %0d ready cycles expected 0", ready_seen);
        end
        read_at(32'h20, d);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL ignore_write_mem: got %h expected cafef00d", d);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_wrap;
        test_zero_count;
        test_back_to_back;
        test_abort;
        test_wr_valid_ignored;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
